// File: rtl/arb_mux_if.sv
// Bundles the request-side and output-side handshakes of arb_mux.
// The req_lock signal exists only when ARB_MUX_LOCK_EN is defined.
interface arb_mux_if #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
);
    localparam int SELW = ($clog2(NCH) > 0) ? $clog2(NCH) : 1;

    logic [NCH-1:0]       req_valid;
    logic [NCH*WIDTH-1:0] req_data;
    logic [NCH-1:0]       req_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;
`ifdef ARB_MUX_LOCK_EN
    logic [NCH-1:0]       req_lock;

    modport master (
        input  req_valid, req_data, out_ready, req_lock,
        output req_ready, out_valid, out_data, out_sel
    );
    modport slave (
        output req_valid, req_data, out_ready, req_lock,
        input  req_ready, out_valid, out_data, out_sel
    );
`else
    modport master (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_sel
    );
    modport slave (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_sel
    );
`endif
endinterface

// File: rtl/arb_mux.sv
// N-channel round-robin arbiter feeding a one-deep registered output stage.
// Optional channel locking is enabled by defining ARB_MUX_LOCK_EN.
module arb_mux #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic      clk,
    input  logic      reset,
    arb_mux_if.master bus
);
    localparam int SELW = ($clog2(NCH) > 0) ? $clog2(NCH) : 1;

    logic [SELW-1:0]  ptr;
    logic [SELW-1:0]  grant;
    logic             found;
    logic             en;
    logic [NCH-1:0]   eligible;
    logic [2*NCH-1:0] doubled;
    logic [NCH-1:0]   rotated;
    int               sum;

`ifdef ARB_MUX_LOCK_EN
    logic             locked;
    logic [SELW-1:0]  lock_ch;

    // A locked channel masks every other requester, even while it is idle.
    always_comb begin
        eligible = bus.req_valid;
        if (locked)
            eligible = bus.req_valid & (NCH'(1) << lock_ch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked  <= 1'b0;
            lock_ch <= '0;
        end else if (en && found) begin
            locked  <= bus.req_lock[grant];
            lock_ch <= grant;
        end
    end
`else
    assign eligible = bus.req_valid;
`endif

    assign en = !bus.out_valid || bus.out_ready;

    // Rotate the request vector so bit 0 is the pointer channel, then take
    // the first set bit and map its offset back to a channel index mod NCH.
    always_comb begin
        found   = 1'b0;
        grant   = '0;
        sum     = 0;
        doubled = {eligible, eligible};
        rotated = NCH'(doubled >> ptr);
        for (int k = 0; k < NCH; k++) begin
            if (!found && rotated[k]) begin
                found = 1'b1;
                sum   = int'(ptr) + k;
                if (sum >= NCH)
                    sum = sum - NCH;
                grant = SELW'(sum);
            end
        end
    end

    assign bus.req_ready = (en && found && !reset) ? (NCH'(1) << grant) : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sel   <= '0;
            ptr           <= '0;
        end else if (en) begin
            if (found) begin
                bus.out_valid <= 1'b1;
                bus.out_data  <= bus.req_data[grant*WIDTH +: WIDTH];
                bus.out_sel   <= grant;
                ptr           <= (grant == SELW'(NCH - 1)) ? '0 : grant + SELW'(1);
            end else begin
                bus.out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_arb_mux.sv
// Directed bench for arb_mux: a 4-channel and a 3-channel instance share clk and reset.
// Defining ARB_MUX_LOCK_EN adds the channel-lock sequence.
module tb_arb_mux;
    logic clk;
    logic reset;
    int   assertCount;
    int   failCount;

    arb_mux_if #(.WIDTH(8), .NCH(4)) bus4 ();
    arb_mux_if #(.WIDTH(8), .NCH(3)) bus3 ();

    arb_mux #(.WIDTH(8), .NCH(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));
    arb_mux #(.WIDTH(8), .NCH(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic ready);
        bus4.req_valid = valid;
        bus4.out_ready = ready;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        assertCount = 0;
        failCount   = 0;

        // Reset held with every channel requesting.
        reset = 1'b1;
        for (int i = 0; i < 4; i++) bus4.req_data[i*8 +: 8] = 8'h10 + 8'(i);
        for (int i = 0; i < 3; i++) bus3.req_data[i*8 +: 8] = 8'h20 + 8'(i);
        bus3.req_valid = 3'b000;
        bus3.out_ready = 1'b1;
`ifdef ARB_MUX_LOCK_EN
        bus4.req_lock = 4'b0000;
        bus3.req_lock = 3'b000;
`endif
        applyStimulus(4'b1111, 1'b1);
        tick();
        tick();
        checkOutput("rst_ready", 32'(bus4.req_ready), 32'h0);
        checkOutput("rst_valid", 32'(bus4.out_valid), 32'h0);
        checkOutput("rst_data", 32'(bus4.out_data), 32'h0);
        checkOutput("rst_sel", 32'(bus4.out_sel), 32'h0);
        checkOutput("rst_valid3", 32'(bus3.out_valid), 32'h0);

        // Continuous requests on all four channels: 0,1,2,3,0,1.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput("rr_ready", 32'(bus4.req_ready), 32'h1 << (i % 4));
            tick();
            checkOutput("rr_valid", 32'(bus4.out_valid), 32'h1);
            checkOutput("rr_sel", 32'(bus4.out_sel), 32'(i % 4));
            checkOutput("rr_data", 32'(bus4.out_data), 32'h10 + 32'(i % 4));
        end

        // Single requester on channel 2.
        bus4.req_data[2*8 +: 8] = 8'hA5;
        applyStimulus(4'b0100, 1'b1);
        #1;
        checkOutput("one_ready", 32'(bus4.req_ready), 32'h4);
        tick();
        checkOutput("one_valid", 32'(bus4.out_valid), 32'h1);
        checkOutput("one_data", 32'(bus4.out_data), 32'hA5);
        checkOutput("one_sel", 32'(bus4.out_sel), 32'h2);

        // No requests: the beat drains, data and select are held.
        applyStimulus(4'b0000, 1'b1);
        #1;
        checkOutput("idle_ready", 32'(bus4.req_ready), 32'h0);
        tick();
        checkOutput("idle_valid", 32'(bus4.out_valid), 32'h0);
        checkOutput("idle_data", 32'(bus4.out_data), 32'hA5);
        checkOutput("idle_sel", 32'(bus4.out_sel), 32'h2);

        // Load 3C from channel 1 while the sink is stalled.
        bus4.req_data[1*8 +: 8] = 8'h3C;
        applyStimulus(4'b0010, 1'b0);
        #1;
        checkOutput("load_ready", 32'(bus4.req_ready), 32'h2);
        tick();
        checkOutput("load_data", 32'(bus4.out_data), 32'h3C);

        // Everyone requests while the sink stays stalled for three cycles.
        bus4.req_data[1*8 +: 8] = 8'h3D;
        applyStimulus(4'b1111, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("stall_ready", 32'(bus4.req_ready), 32'h0);
            tick();
            checkOutput("stall_valid", 32'(bus4.out_valid), 32'h1);
            checkOutput("stall_data", 32'(bus4.out_data), 32'h3C);
            checkOutput("stall_sel", 32'(bus4.out_sel), 32'h1);
        end

        // Release: the pointer sits after channel 1, so channel 2 wins.
        applyStimulus(4'b1111, 1'b1);
        #1;
        checkOutput("rel_ready", 32'(bus4.req_ready), 32'h4);
        tick();
        checkOutput("rel_sel", 32'(bus4.out_sel), 32'h2);
        checkOutput("rel_data", 32'(bus4.out_data), 32'hA5);
        applyStimulus(4'b0000, 1'b0);

        // Three channels: the pointer wraps at 3, giving 0,1,2,0.
        bus3.req_valid = 3'b111;
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("wrap_ready", 32'(bus3.req_ready), 32'h1 << (i % 3));
            tick();
            checkOutput("wrap_sel", 32'(bus3.out_sel), 32'(i % 3));
            checkOutput("wrap_data", 32'(bus3.out_data), 32'h20 + 32'(i % 3));
        end

        // Reset mid-stream drops the held beat and returns the pointer to 0.
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_ready", 32'(bus3.req_ready), 32'h0);
        tick();
        checkOutput("mid_rst_valid3", 32'(bus3.out_valid), 32'h0);
        checkOutput("mid_rst_valid4", 32'(bus4.out_valid), 32'h0);
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_ptr", 32'(bus3.req_ready), 32'h1);
        tick();
        checkOutput("mid_rst_sel", 32'(bus3.out_sel), 32'h0);
        bus3.req_valid = 3'b000;

`ifdef ARB_MUX_LOCK_EN
        // Move the pointer to 1 with a lone channel-0 beat.
        applyStimulus(4'b0001, 1'b1);
        #1;
        checkOutput("lock_pre_ready", 32'(bus4.req_ready), 32'h1);
        tick();
        // Channel 1 locks for three beats, unlocks on the fourth, then channel 2.
        bus4.req_data[1*8 +: 8] = 8'h3D;
        applyStimulus(4'b0111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            bus4.req_lock = (i < 3) ? 4'b0010 : 4'b0000;
            #1;
            checkOutput("lock_ready", 32'(bus4.req_ready), (i < 4) ? 32'h2 : 32'h4);
            tick();
            checkOutput("lock_sel", 32'(bus4.out_sel), (i < 4) ? 32'h1 : 32'h2);
        end
        applyStimulus(4'b0000, 1'b1);
        bus4.req_lock = 4'b0000;
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
